cp0_timer: RTL

CP0_TIMER -- requirements
Module: cp0_timer

---
 rtl/cp0_timer.sv | 261 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/cp0_timer.sv
// -----------------------------------------------------------------------------
// cp0_timer
//   Minimal MIPS-style coprocessor-0: status/cause/EPC/BadVAddr/PRId registers,
//   a free-running Count/Compare timer and the trap request logic for the
//   M stage of the pipeline.
//
// Parameters
//   NUM_HWINT  : number of external interrupt lines (1..6)
//   TIMER_EN   : 1 = Count/Compare timer present, 0 = timer reads 0, TI stays 0
//   PRID_VALUE : read-only PRId contents
//
// Ports
//   clk        : clock, all state updates on the rising edge
//   reset      : asynchronous active-low reset
//   rd_addr    : mfc0 register number (combinational read on rd_data)
//   wr_addr    : mtc0 register number
//   wr_data    : mtc0 data
//   we         : mtc0 strobe
//   pc         : PC of the instruction in M stage (trap victim)
//   bd         : victim sits in a branch delay slot
//   valid      : M stage holds a real instruction
//   exc_code   : nonzero = synchronous exception raised by the victim
//   bad_vaddr  : faulting address for address-error exceptions
//   eret       : return from exception
//   hw_int     : level-sensitive external interrupt lines
//   int_req    : take the trap this cycle
//   epc_out    : current EPC register
//   rd_data    : mfc0 read data
// -----------------------------------------------------------------------------
module cp0_timer #(
    parameter int          NUM_HWINT  = 6,
    parameter int          TIMER_EN   = 1,
    parameter logic [31:0] PRID_VALUE = 32'h12345678
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [4:0]           rd_addr,
    input  logic [4:0]           wr_addr,
    input  logic [31:0]          wr_data,
    input  logic                 we,
    input  logic [31:0]          pc,
    input  logic                 bd,
    input  logic                 valid,
    input  logic [4:0]           exc_code,
    input  logic [31:0]          bad_vaddr,
    input  logic                 eret,
    input  logic [NUM_HWINT-1:0] hw_int,
    output logic                 int_req,
    output logic [31:0]          epc_out,
    output logic [31:0]          rd_data
);

    localparam logic [4:0] ADDR_BADVADDR = 5'd8;
    localparam logic [4:0] ADDR_COUNT    = 5'd9;
    localparam logic [4:0] ADDR_COMPARE  = 5'd11;
    localparam logic [4:0] ADDR_SR       = 5'd12;
    localparam logic [4:0] ADDR_CAUSE    = 5'd13;
    localparam logic [4:0] ADDR_EPC      = 5'd14;
    localparam logic [4:0] ADDR_PRID     = 5'd15;

    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;

    // Address-error exceptions are the only ones that capture BadVAddr.
    function automatic logic is_addr_fault(input logic [4:0] code);
        logic hit;
        case (code)
            EXC_ADEL: hit = 1'b1;
            EXC_ADES: hit = 1'b1;
            default:  hit = 1'b0;
        endcase
        return hit;
    endfunction

    // Word-aligned return address; a delay-slot victim restarts at its branch.
    function automatic logic [31:0] trap_epc(input logic [31:0] victim_pc,
                                             input logic        in_slot);
        logic [31:0] aligned;
        aligned = {victim_pc[31:2], 2'b00};
        return in_slot ? (aligned - 32'd4) : aligned;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [5:0]  im_r;
    logic        exl_r;
    logic        ie_r;
    logic        bd_r;
    logic        ti_r;
    logic [5:0]  hw_ip_r;
    logic [4:0]  exc_code_r;
    logic [31:0] epc_r;
    logic [31:0] badvaddr_r;
    logic [31:0] count_r;
    logic [31:0] compare_r;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic [5:0]  hw_pad_s;
    logic [5:0]  ip_s;
    logic        int_pending_s;
    logic        exc_s;
    logic        trap_s;
    logic        wr_ok_s;
    logic        wr_sr_s;
    logic        wr_epc_s;
    logic        wr_count_s;
    logic        wr_compare_s;
    logic [31:0] count_inc_s;
    logic        ti_set_s;
    logic [31:0] sr_s;
    logic [31:0] cause_s;
    logic        unused_ok_s;

    // Lines beyond NUM_HWINT are tied low so their IP bits always read 0.
    for (genvar g = 0; g < 6; g++) begin : g_hw_pad
        if (g < NUM_HWINT) begin : g_live
            assign hw_pad_s[g] = hw_int[g];
        end else begin : g_tied
            assign hw_pad_s[g] = 1'b0;
        end
    end

    // The low PC bits are dropped when forming EPC.
    assign unused_ok_s = &{1'b0, pc[1:0]};

    // Pending-interrupt, trap and mtc0 decode.
    always_comb begin
        ip_s          = {hw_ip_r[5] | ti_r, hw_ip_r[4:0]};
        int_pending_s = (|(ip_s & im_r)) & ie_r & ~exl_r;
        exc_s         = (exc_code != 5'd0);
        // Gating with reset keeps int_req low while reset is asserted even
        // when an exception code is presented.
        trap_s        = reset & valid & (int_pending_s | exc_s);
        // A trap in the same cycle swallows the mtc0.
        wr_ok_s       = we & ~trap_s;
        wr_sr_s       = wr_ok_s & (wr_addr == ADDR_SR);
        wr_epc_s      = wr_ok_s & (wr_addr == ADDR_EPC);
        wr_count_s    = wr_ok_s & (wr_addr == ADDR_COUNT);
        wr_compare_s  = wr_ok_s & (wr_addr == ADDR_COMPARE);
        count_inc_s   = count_r + 32'd1;
        // Only an increment can raise TI; loading Count by mtc0 never does.
        if (TIMER_EN != 0) begin
            ti_set_s = ~wr_count_s & (count_inc_s == compare_r);
        end else begin
            ti_set_s = 1'b0;
        end
    end

    // Trap request and EPC outputs.
    always_comb begin
        int_req = trap_s;
        epc_out = epc_r;
    end

    // ------------------------------------------------------------------
    // Sequential logic
    // ------------------------------------------------------------------

    // Sample the external interrupt lines once per cycle into IP.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hw_ip_r <= 6'b0;
        end else begin
            hw_ip_r <= hw_pad_s;
        end
    end

    // Count/Compare timer and the TI flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_r   <= 32'd0;
            compare_r <= 32'hFFFF_FFFF;
            ti_r      <= 1'b0;
        end else if (TIMER_EN != 0) begin
            if (wr_count_s) begin
                count_r <= wr_data;
            end else begin
                count_r <= count_inc_s;
            end
            if (wr_compare_s) begin
                compare_r <= wr_data;
            end
            // A Compare write acknowledges the timer interrupt.
            if (wr_compare_s) begin
                ti_r <= 1'b0;
            end else if (ti_set_s) begin
                ti_r <= 1'b1;
            end
        end else begin
            count_r <= 32'd0;
            ti_r    <= 1'b0;
        end
    end

    // Status, cause, EPC and BadVAddr: trap entry, eret and mtc0 updates.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            im_r       <= 6'b0;
            exl_r      <= 1'b0;
            ie_r       <= 1'b0;
            bd_r       <= 1'b0;
            exc_code_r <= 5'd0;
            epc_r      <= 32'd0;
            badvaddr_r <= 32'd0;
        end else if (trap_s) begin
            // Nested exceptions (EXL already set) keep the original EPC/BD.
            if (!exl_r) begin
                exl_r <= 1'b1;
                bd_r  <= bd;
                epc_r <= trap_epc(pc, bd);
            end
            if (int_pending_s) begin
                exc_code_r <= 5'd0;
            end else begin
                exc_code_r <= exc_code;
                if (is_addr_fault(exc_code)) begin
                    badvaddr_r <= bad_vaddr;
                end
            end
        end else begin
            if (wr_sr_s) begin
                im_r <= wr_data[15:10];
                ie_r <= wr_data[0];
            end
            // eret wins over an mtc0 to SR.EXL in the same cycle.
            if (eret) begin
                exl_r <= 1'b0;
                bd_r  <= 1'b0;
            end else if (wr_sr_s) begin
                exl_r <= wr_data[1];
            end
            if (wr_epc_s) begin
                epc_r <= {wr_data[31:2], 2'b00};
            end
        end
    end

    // ------------------------------------------------------------------
    // mfc0 read path (current register state, no write bypass)
    // ------------------------------------------------------------------

    // Assemble SR/Cause images and select the addressed register.
    always_comb begin
        sr_s    = {16'b0, im_r, 8'b0, exl_r, ie_r};
        cause_s = {bd_r, ti_r, 14'b0, ip_s, 3'b0, exc_code_r, 2'b00};
        case (rd_addr)
            ADDR_BADVADDR: rd_data = badvaddr_r;
            ADDR_COUNT:    rd_data = (TIMER_EN != 0) ? count_r : 32'd0;
            ADDR_COMPARE:  rd_data = (TIMER_EN != 0) ? compare_r : 32'd0;
            ADDR_SR:       rd_data = sr_s;
            ADDR_CAUSE:    rd_data = cause_s;
            ADDR_EPC:      rd_data = epc_r;
            ADDR_PRID:     rd_data = PRID_VALUE;
            default:       rd_data = 32'd0;
        endcase
    end

endmodule
